hp_rd_arbiter: RTL and testbench

Two-master AXI4 read-channel arbiter that shares one PS HP slave port (AR and R channels) between the TLK2711-A and TLK2711-B transmit DMA engines. It grants one whole burst at a time in round-robin order and routes the R beats back to the granted master until RLAST. It also keeps a sticky per-master error flag for non-OKAY responses. It sits between the tlk2711 wrapper's read masters and the mpsoc HP slave, all on clk_100.

---
 rtl/tlk2711_pkg.sv | 16 +
 rtl/hp_rd_arbiter_if.sv | 44 ++++
 rtl/rr_arb2.sv | 19 +
 rtl/hp_rd_arbiter.sv | 149 ++++++++++++++
 tb/tb_hp_rd_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlk2711_pkg.sv
// rtl/tlk2711_pkg.sv - shared constants and types for the tlk2711 AXI helpers
package tlk2711_pkg;

    localparam int DEF_ADDR_WIDTH = 40;
    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_ID_WIDTH   = 4;

    localparam logic [1:0] OKAY = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/hp_rd_arbiter_if.sv
// rtl/hp_rd_arbiter_if.sv - AXI4 read channel (AR + R) bundle
interface hp_rd_arbiter_if
    import tlk2711_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH
);

    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [2:0]            arprot;
    logic [3:0]            arcache;
    logic [3:0]            aruser;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [ID_WIDTH-1:0]   rid;

    // Read master: issues AR, consumes R
    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, arprot, arcache, aruser,
        output rready,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid
    );

    // Read slave: accepts AR, returns R
    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, arprot, arcache, aruser,
        input  rready,
        output arready,
        output rvalid, rdata, rresp, rlast, rid
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin picker
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] grant
);

    // A lone requester wins; on contention the master that did not win last time wins
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_owner ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/hp_rd_arbiter.sv
// rtl/hp_rd_arbiter.sv - burst-granular round-robin read arbiter for the PS HP port
module hp_rd_arbiter
    import tlk2711_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    hp_rd_arbiter_if.slave     m0,
    hp_rd_arbiter_if.slave     m1,
    hp_rd_arbiter_if.master    s,
    input  logic [1:0]         i_err_clr,
    output logic [1:0]         o_err,
    output logic [1:0]         o_grant,
    output logic               o_busy
);

    arb_state_t state_q, state_d;
    logic [1:0] grant_q;
    logic       last_owner_q;
    logic [1:0] err_q;
    logic [1:0] pick;
    logic [1:0] req;
    logic       sel1;
    logic       sel_arvalid;
    logic       sel_rready;
    logic       beat_acc;
    logic [1:0] err_set;

    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [ID_WIDTH-1:0]   ar_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ID_WIDTH-1:0]   r_id;

    assign req         = {m1.arvalid, m0.arvalid};
    assign sel1        = grant_q[1];
    assign sel_arvalid = sel1 ? m1.arvalid : m0.arvalid;
    assign sel_rready  = sel1 ? m1.rready  : m0.rready;

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_owner (last_owner_q),
        .grant      (pick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake steering; only the owner ever sees a valid/ready
    always_comb begin
        state_d    = state_q;
        s.arvalid  = 1'b0;
        m0.arready = 1'b0;
        m1.arready = 1'b0;
        s.rready   = 1'b0;
        m0.rvalid  = 1'b0;
        m1.rvalid  = 1'b0;
        o_busy     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_AR;
                end
            end
            S_AR: begin
                o_busy     = 1'b1;
                s.arvalid  = sel_arvalid;
                m0.arready = grant_q[0] & s.arready;
                m1.arready = grant_q[1] & s.arready;
                if (sel_arvalid && s.arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                o_busy    = 1'b1;
                s.rready  = sel_rready;
                m0.rvalid = grant_q[0] & s.rvalid;
                m1.rvalid = grant_q[1] & s.rvalid;
                if (s.rvalid && sel_rready && s.rlast) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grant is latched when leaving idle and held for the whole burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q      <= 2'b00;
            last_owner_q <= 1'b1;
        end else if (state_q == S_IDLE && state_d == S_AR) begin
            grant_q      <= pick;
            last_owner_q <= pick[1];
        end else if (state_q == S_R && state_d == S_IDLE) begin
            grant_q      <= 2'b00;
        end
    end

    assign beat_acc = (state_q == S_R) && s.rvalid && sel_rready;
    assign err_set  = grant_q & {2{beat_acc && (s.rresp != OKAY)}};

    // Sticky error per master; a new error in the clear cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 2'b00;
        end else begin
            err_q <= (err_q & ~i_err_clr) | err_set;
        end
    end

    assign o_err   = err_q;
    assign o_grant = grant_q;

    // AR payload follows the owner; meaningful only while s.arvalid is high
    assign ar_addr   = sel1 ? m1.araddr  : m0.araddr;
    assign ar_id     = sel1 ? m1.arid    : m0.arid;
    assign s.araddr  = ar_addr;
    assign s.arid    = ar_id;
    assign s.arlen   = sel1 ? m1.arlen   : m0.arlen;
    assign s.arsize  = sel1 ? m1.arsize  : m0.arsize;
    assign s.arburst = sel1 ? m1.arburst : m0.arburst;
    assign s.arprot  = sel1 ? m1.arprot  : m0.arprot;
    assign s.arcache = sel1 ? m1.arcache : m0.arcache;
    assign s.aruser  = sel1 ? m1.aruser  : m0.aruser;

    // R payload is broadcast; rvalid alone selects the recipient
    assign r_data   = s.rdata;
    assign r_id     = s.rid;
    assign m0.rdata = r_data;
    assign m1.rdata = r_data;
    assign m0.rid   = r_id;
    assign m1.rid   = r_id;
    assign m0.rresp = s.rresp;
    assign m1.rresp = s.rresp;
    assign m0.rlast = s.rlast;
    assign m1.rlast = s.rlast;

endmodule

// File: tb/tb_hp_rd_arbiter.sv
// tb/tb_hp_rd_arbiter.sv - self-checking bench for hp_rd_arbiter
module tb_hp_rd_arbiter;
    import tlk2711_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] err_clr;
    logic [1:0] o_err;
    logic [1:0] o_grant;
    logic       o_busy;

    always #5 clk = ~clk;

    hp_rd_arbiter_if m0_if ();
    hp_rd_arbiter_if m1_if ();
    hp_rd_arbiter_if s_if ();

    hp_rd_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .i_err_clr (err_clr),
        .o_err     (o_err),
        .o_grant   (o_grant),
        .o_busy    (o_busy)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: who last won, pending requests, sticky errors, AR field sets
    int          mdl_last;
    logic [1:0]  mdl_err;
    bit          pend [2];
    logic [67:0] fld  [2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_ar(input int m, input logic [67:0] v, input logic valid);
        if (m == 0) begin
            {m0_if.araddr, m0_if.arlen, m0_if.arid, m0_if.arsize, m0_if.arburst,
             m0_if.arprot, m0_if.arcache, m0_if.aruser} = v;
            m0_if.arvalid = valid;
        end else begin
            {m1_if.araddr, m1_if.arlen, m1_if.arid, m1_if.arsize, m1_if.arburst,
             m1_if.arprot, m1_if.arcache, m1_if.aruser} = v;
            m1_if.arvalid = valid;
        end
    endtask

    task automatic set_req(input int m, input logic [39:0] addr, input logic [7:0] len);
        logic [67:0] v;
        v = {addr, len, 4'($urandom), 3'($urandom), 2'($urandom),
             3'($urandom), 4'($urandom), 4'($urandom)};
        fld[m]  = v;
        pend[m] = 1'b1;
        drive_ar(m, v, 1'b1);
    endtask

    task automatic set_rready(input int m, input logic v);
        if (m == 0) m0_if.rready = v;
        else        m1_if.rready = v;
    endtask

    function automatic logic [67:0] s_ar_pack();
        return {s_if.araddr, s_if.arlen, s_if.arid, s_if.arsize, s_if.arburst,
                s_if.arprot, s_if.arcache, s_if.aruser};
    endfunction

    function automatic logic m_arready(input int m);
        return (m == 0) ? m0_if.arready : m1_if.arready;
    endfunction

    function automatic logic m_rvalid(input int m);
        return (m == 0) ? m0_if.rvalid : m1_if.rvalid;
    endfunction

    function automatic logic [127:0] m_rdata(input int m);
        return (m == 0) ? m0_if.rdata : m1_if.rdata;
    endfunction

    // Lone requester wins; on contention the one that is not the previous winner wins
    function automatic int mdl_pick();
        if (pend[0] && pend[1]) return 1 - mdl_last;
        return pend[1] ? 1 : 0;
    endfunction

    function automatic logic [39:0] rand_addr();
        return {8'($urandom), 32'($urandom)};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        err_clr = 2'b00;
        m0_if.rready = 1'b0;
        m1_if.rready = 1'b0;
        drive_ar(0, 68'd0, 1'b0);
        drive_ar(1, 68'd0, 1'b0);
        s_if.arready = 1'b0;
        s_if.rvalid  = 1'b0;
        s_if.rdata   = '0;
        s_if.rresp   = 2'b00;
        s_if.rlast   = 1'b0;
        s_if.rid     = '0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        mdl_last = 1;
        mdl_err  = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One whole burst from grant to the idle turnaround cycle.
    // Entry and exit: 2 time units after a rising edge, during an idle cycle.
    task automatic serve(input int ar_wait, input int rmode, input int err_beat, input bit rand_resp);
        int w, o, nbeats, beat, budget;
        logic vld, rdy, acc;
        logic [1:0] resp, clr, g;
        logic [127:0] dat;
        chk("idle_arvalid", s_if.arvalid, 1'b0);
        w = mdl_pick();
        o = 1 - w;
        mdl_last = w;
        g = 2'b01 << w;
        tick();
        chk("ar_grant", o_grant, g);
        chk("ar_busy", o_busy, 1'b1);
        chk("ar_valid", s_if.arvalid, 1'b1);
        chk("ar_fields", s_ar_pack(), fld[w]);
        chk("ar_rready", s_if.rready, 1'b0);
        for (int i = 0; i < ar_wait; i++) begin
            chk("ar_wait_ready", m_arready(w), 1'b0);
            tick();
            chk("ar_stable_valid", s_if.arvalid, 1'b1);
            chk("ar_stable_fields", s_ar_pack(), fld[w]);
        end
        s_if.arready = 1'b1;
        #1;
        chk("ar_ready_owner", m_arready(w), 1'b1);
        chk("ar_ready_other", m_arready(o), 1'b0);
        tick();
        s_if.arready = 1'b0;
        pend[w] = 1'b0;
        drive_ar(w, fld[w], 1'b0);
        nbeats = int'(fld[w][27:20]) + 1;
        beat = 0;
        budget = 0;
        while (beat < nbeats && budget < 300) begin
            budget++;
            vld = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = budget[0];
                default: rdy = 1'($urandom);
            endcase
            clr = 2'b00;
            if (rand_resp) begin
                resp = 2'($urandom);
                if ($urandom_range(0, 3) == 0) clr = 2'($urandom);
            end else if (beat == err_beat) begin
                resp = 2'b10;
                clr  = g;
            end else begin
                resp = OKAY;
            end
            dat = {$urandom, $urandom, $urandom, $urandom};
            s_if.rvalid = vld;
            s_if.rdata  = dat;
            s_if.rresp  = resp;
            s_if.rlast  = (beat == nbeats - 1);
            set_rready(w, rdy);
            set_rready(o, 1'($urandom));
            err_clr = clr;
            #1;
            chk("r_grant", o_grant, g);
            chk("r_sready", s_if.rready, rdy);
            chk("r_valid_owner", m_rvalid(w), vld);
            chk("r_valid_other", m_rvalid(o), 1'b0);
            chk("r_bcast", m_rdata(o), dat);
            acc = vld & rdy;
            mdl_err = (mdl_err & ~clr) | ((acc && resp != OKAY) ? g : 2'b00);
            tick();
            err_clr = 2'b00;
            chk("err_flag", o_err, mdl_err);
            if (acc) beat++;
        end
        chk("beat_count", beat, nbeats);
        s_if.rvalid = 1'b0;
        s_if.rlast  = 1'b0;
        chk("turn_busy", o_busy, 1'b0);
        chk("turn_grant", o_grant, 2'b00);
        chk("turn_arvalid", s_if.arvalid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, checked while reset is still asserted
        rst_n = 1'b0;
        err_clr = 2'b00;
        m0_if.rready = 1'b0;
        m1_if.rready = 1'b0;
        drive_ar(0, 68'd0, 1'b0);
        drive_ar(1, 68'd0, 1'b0);
        s_if.arready = 1'b0;
        s_if.rvalid = 1'b0;
        s_if.rdata = '0;
        s_if.rresp = 2'b00;
        s_if.rlast = 1'b0;
        s_if.rid = '0;
        #3;
        chk("rst_grant", o_grant, 2'b00);
        chk("rst_err", o_err, 2'b00);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_s_arvalid", s_if.arvalid, 1'b0);
        chk("rst_s_rready", s_if.rready, 1'b0);
        chk("rst_m0_arready", m0_if.arready, 1'b0);
        chk("rst_m1_rvalid", m1_if.rvalid, 1'b0);
        do_reset();

        // Single master, fixed address, 4 beats
        set_req(0, 40'h10_0000_0000, 8'd3);
        serve(0, 0, -1, 1'b0);

        // Contention straight after reset, with the winner re-requesting each time
        do_reset();
        set_req(0, rand_addr(), 8'($urandom_range(0, 3)));
        set_req(1, rand_addr(), 8'd0);
        for (int k = 0; k < 3; k++) begin
            serve(0, 0, -1, 1'b0);
            set_req(mdl_last, rand_addr(), 8'($urandom_range(0, 2)));
        end
        serve(0, 0, -1, 1'b0);
        serve(0, 0, -1, 1'b0);

        // Backpressure: AR stall then toggling rready on an 8-beat burst
        set_req(0, rand_addr(), 8'd7);
        serve(5, 1, -1, 1'b0);

        // Error on m1 with a simultaneous clear, then a lone clear
        set_req(1, rand_addr(), 8'd1);
        serve(0, 0, 0, 1'b0);
        err_clr = 2'b10;
        mdl_err = mdl_err & ~2'b10;
        tick();
        err_clr = 2'b00;
        chk("err_lone_clear", o_err, mdl_err);

        // Stray R beat while idle must stall at the slave
        s_if.rvalid = 1'b1;
        s_if.rlast  = 1'b1;
        m0_if.rready = 1'b1;
        m1_if.rready = 1'b1;
        #1;
        chk("stray_rready", s_if.rready, 1'b0);
        chk("stray_m0_rvalid", m0_if.rvalid, 1'b0);
        tick();
        chk("stray_rready_held", s_if.rready, 1'b0);
        chk("stray_busy", o_busy, 1'b0);
        s_if.rvalid = 1'b0;
        s_if.rlast  = 1'b0;

        // Randomized traffic against the model
        for (int k = 0; k < 25; k++) begin
            if (!pend[0] && $urandom_range(0, 1) == 1) set_req(0, rand_addr(), 8'($urandom_range(0, 5)));
            if (!pend[1] && $urandom_range(0, 1) == 1) set_req(1, rand_addr(), 8'($urandom_range(0, 5)));
            if (!pend[0] && !pend[1]) set_req($urandom_range(0, 1), rand_addr(), 8'($urandom_range(0, 5)));
            serve($urandom_range(0, 3), 2, -1, 1'b1);
        end
        while (pend[0] || pend[1]) serve(0, 0, -1, 1'b0);

        // Asynchronous reset in the middle of a burst
        set_req(1, rand_addr(), 8'd1);
        serve(0, 0, 0, 1'b0);
        set_req(0, rand_addr(), 8'd5);
        tick();
        s_if.arready = 1'b1;
        tick();
        s_if.arready = 1'b0;
        drive_ar(0, fld[0], 1'b0);
        pend[0] = 1'b0;
        s_if.rvalid = 1'b1;
        m0_if.rready = 1'b1;
        #1;
        chk("mid_rvalid", m0_if.rvalid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", o_busy, 1'b0);
        chk("arst_grant", o_grant, 2'b00);
        chk("arst_err", o_err, 2'b00);
        chk("arst_s_rready", s_if.rready, 1'b0);
        chk("arst_m0_rvalid", m0_if.rvalid, 1'b0);
        chk("arst_s_arvalid", s_if.arvalid, 1'b0);
        do_reset();

        // After reset master 0 again wins the first contention
        set_req(0, rand_addr(), 8'd0);
        set_req(1, rand_addr(), 8'd0);
        serve(0, 0, -1, 1'b0);
        serve(0, 0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
